ex_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit in the EX stage, directly upstream of the EX->MEM pipeline register.

---
 rtl/ex_muldiv_if.sv | 14 +
 rtl/ex_muldiv_unit.sv | 109 ++++++++++
 tb/tb_ex_muldiv_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: request/result bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Stall;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  modport master (output Start, Op, A, B, input Busy, Stall, Done, HI, LO);
  modport slave  (input Start, Op, A, B, output Busy, Stall, Done, HI, LO);
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU producing {HI,LO}; shift-add multiply, restoring divide.
// Defining MULDIV_FAST_MUL_EN switches multiplies to a single-cycle full-width product.
module ex_muldiv_unit #(parameter int WIDTH = 32) (
  input logic       clk,
  input logic       CLR,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               is_div, sgn, div_ok, neg_res, neg_a, last;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_nxt, prod, prod_f;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt, quo_f, rem_f, a_orig;
  assign is_div   = op_q[1];
  assign sgn      = ~op_q[0];
  assign neg_res  = sgn & (sa_q ^ sb_q);
  assign neg_a    = sgn & sa_q;
  // Multiply: low half of acc holds the unconsumed multiplier bits, high half the partial product.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? a_q : {WIDTH{1'b0}}};
  assign mul_nxt  = {mul_sum, acc_q[WIDTH-1:1]};
  // Divide: low half of acc shifts the dividend out and the quotient in.
  assign div_sh   = {rem_q, acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_ok   = ~div_diff[WIDTH];
  assign rem_nxt  = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign quo_nxt  = {acc_q[WIDTH-2:0], div_ok};
  assign quo_f    = neg_res ? -quo_nxt : quo_nxt;
  assign rem_f    = neg_a ? -rem_nxt : rem_nxt;
  assign a_orig   = neg_a ? -a_q : a_q;
`ifdef MULDIV_FAST_MUL_EN
  assign prod     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign last     = ~is_div | (cnt_q == CW'(WIDTH-1));
`else
  assign prod     = mul_nxt;
  assign last     = cnt_q == CW'(WIDTH-1);
`endif
  assign prod_f   = neg_res ? -prod : prod;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == IDLE && bus.Start) begin
      state_d = CALC;
      op_d    = bus.Op;
      sa_d    = ~bus.Op[0] & bus.A[WIDTH-1];
      sb_d    = ~bus.Op[0] & bus.B[WIDTH-1];
      a_d     = sa_d ? -bus.A : bus.A;
      b_d     = sb_d ? -bus.B : bus.B;
      acc_d   = {{WIDTH{1'b0}}, bus.Op[1] ? a_d : b_d};
      rem_d   = '0;
      cnt_d   = '0;
    end else if (state_q == CALC) begin
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      acc_d   = is_div ? {{WIDTH{1'b0}}, quo_nxt} : mul_nxt;
      rem_d   = is_div ? rem_nxt : rem_q;
      state_d = last ? DONE : CALC;
      hi_d    = !last ? hi_q : is_div ? (b_q == '0 ? a_orig : rem_f) : prod_f[2*WIDTH-1:WIDTH];
      lo_d    = !last ? lo_q : is_div ? (b_q == '0 ? {WIDTH{1'b1}} : quo_f) : prod_f[WIDTH-1:0];
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (CLR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign bus.Busy  = state_q != IDLE;
  assign bus.Stall = (bus.Start & (state_q == IDLE)) | (state_q == CALC);
  assign bus.Done  = state_q == DONE;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed vectors for ex_muldiv_unit with hand-computed HI/LO, latency and stall counts.
module tb_ex_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0;
  logic CLR;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  ex_muldiv_if #(.WIDTH(W)) bus();
  ex_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .CLR(CLR), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] hi, input logic [W-1:0] lo, input bit hold);
    int n = 0;
    int st = 0;
    int lat;
    lat = (!op[1] && FAST) ? 2 : W + 1;
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    #1;
    while (!bus.Done && n < 200) begin
      if (bus.Stall) st++;
      @(posedge clk);
      #1;
      if (hold) begin
        bus.Op = ~op;
        bus.A  = ~a;
        bus.B  = b + 32'd3;
      end else bus.Start = 1'b0;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_stall_cycles"}, 64'(st), 64'(lat));
    chk({tag, "_hi"}, 64'(bus.HI), 64'(hi));
    chk({tag, "_lo"}, 64'(bus.LO), 64'(lo));
    chk({tag, "_busy_done"}, 64'(bus.Busy), 64'd1);
    chk({tag, "_stall_done"}, 64'(bus.Stall), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_busy_after"}, 64'(bus.Busy), 64'd0);
    chk({tag, "_done_after"}, 64'(bus.Done), 64'd0);
    chk({tag, "_hold"}, {bus.HI, bus.LO}, {hi, lo});
    bus.Start = 1'b0;
  endtask
  initial begin
    CLR = 1'b1;
    bus.Start = 1'b0;
    bus.Op = 2'b00;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(posedge clk);
    #1 CLR = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_stall", 64'(bus.Stall), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_hilo", {bus.HI, bus.LO}, 64'd0);
    run("multu_max", 2'b01, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE, 1'b0);
    run("mult_neg", 2'b00, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run("mult_m1m1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0);
    run("div_neg", 2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("div_negb", 2'b10, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0);
    run("divu_by0", 2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b0);
    run("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    run("mult_hold", 2'b00, 32'h5, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC, 1'b1);
    run("divu_basic", 2'b11, 32'h7, 32'h2, 32'h1, 32'h3, 1'b0);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op = 2'b11;
    bus.A = 32'd100;
    bus.B = 32'd7;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (9) @(posedge clk);
    #1 CLR = 1'b1;
    @(posedge clk);
    #1 CLR = 1'b0;
    chk("clr_busy", 64'(bus.Busy), 64'd0);
    chk("clr_stall", 64'(bus.Stall), 64'd0);
    chk("clr_done", 64'(bus.Done), 64'd0);
    chk("clr_hilo", {bus.HI, bus.LO}, 64'd0);
    run("post_clr", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
